mem44_drain: RTL
================

// Module: mem44_drain
// PURPOSE
//  Result collector at the output end of the 4x4 systolic array, the inverse of the byte-write/column-read input memory.
//  Captures N skewed per-lane result streams into an NxN byte buffer (lane i -> row i, arrival order -> column).
//  Once every lane has delivered N bytes, streams the buffer out one byte per handshake, row-major.
//  Each output byte carries its {row,col} address, so the stream can drive a byte-addressed write port directly.
// PARAMETERS
//  N   4  array dimension (lanes, and bytes per lane); power of two
//  DW  8  bits per element
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          synchronous, active-high
//  start      in   1          begin a capture; honoured only in IDLE
//  lane_valid in   N          bit i: lane i byte present this cycle
//  lane_data  in   N*DW       lane i byte = lane_data[i*DW +: DW]
//  busy       out  1          high in CAPTURE and DRAIN
//  out_valid  out  1          output byte available
//  out_ready  in   1          consumer accepts byte
//  out_data   out  DW         byte at out_addr
//  out_addr   out  2*log2(N)  {row,col} of out_data
//  out_last   out  1          high with out_valid on final byte (addr N*N-1)
//  done       out  1          one-cycle pulse after final byte transfers
//  overflow   out  1          sticky: lane_valid on an already-full lane during CAPTURE
// BEHAVIOUR
//  Reset: state IDLE, all lane write pointers 0, read pointer 0, buffer zeroed;
//   busy=0, out_valid=0, out_last=0, done=0, overflow=0. out_data=0, out_addr=0.
//  Reset has priority over all other inputs; asserting it mid-CAPTURE or mid-DRAIN
//   abandons the operation and returns the block to the reset state.
//  States: IDLE -> CAPTURE -> DRAIN -> IDLE.
//  IDLE: lane_valid ignored. start=1 -> CAPTURE next cycle; clears wr_ptr[*] and overflow.
//   Buffer contents are retained until overwritten.
//  CAPTURE: for each lane i with lane_valid[i]=1 and wr_ptr[i]<N:
//   buf[i][wr_ptr[i]] <= lane byte; wr_ptr[i]++. Lanes are fully independent,
//   so arbitrary skew is allowed. Any number of lanes may write in the same cycle.
//   lane_valid[i]=1 with wr_ptr[i]==N: data dropped, overflow <= 1.
//   When all wr_ptr==N (counting writes made this cycle), next state is DRAIN and rd_ptr <= 0.
//   start is ignored.
//  DRAIN: out_valid=1. out_addr=rd_ptr. out_data=buf[rd_ptr[hi]][rd_ptr[lo]].
//   All three are registered/stable while out_valid && !out_ready.
//   A transfer occurs when out_valid && out_ready: rd_ptr++.
//   A transfer at rd_ptr==N*N-1 -> IDLE next cycle, done=1 for exactly that one cycle, out_valid=0.
//   lane_valid and start are ignored in DRAIN (no overflow).
//  Latency: first out_valid is the cycle after the last lane's Nth byte is written.
//   Maximum throughput is 1 byte/clk when out_ready is held high.
//  start in the same cycle as the final drain transfer is ignored.
//   A new capture requires start again once state is IDLE (first possible: the done cycle).
//  busy = (state != IDLE). overflow holds until the next accepted start or reset.
// TESTING
//  1. Reset, start, all lanes valid 4 cycles with byte=16*lane+k
//     -> DRAIN after cycle 4; 16 bytes out 0x00..0x03,0x10..0x33
//     -> addr 0..15, out_last on addr 15, done pulse.
//  2. Skewed input, lane i starts i cycles late (diagonal)
//     -> same buffer as test 1; out_valid first high the cycle after lane 3's 4th byte.
//  3. Backpressure: out_ready toggles 1,0,0,1,...
//     -> out_data/out_addr stable while stalled; no byte lost or duplicated; 16 transfers total.
//  4. Lane 2 sends a 5th byte 0xEE during CAPTURE
//     -> overflow=1; byte dropped (addr 0xB still holds 4th byte); overflow cleared by next start.
//  5. Reset asserted after 2 bytes/lane in CAPTURE -> IDLE, busy=0;
//     -> new full capture drains only new data, no stale pointers.
//  6. start held high through DRAIN end -> ignored until IDLE; capture restarts on the done cycle, next cycle busy=1.

Source files
------------

// File: rtl/mem44_drain_if.sv
// Output byte stream of the systolic result collector: valid/ready handshake
// carrying the byte, its {row,col} address and a last-byte flag.
interface mem44_drain_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int AW = $clog2(N);

    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [2*AW-1:0]   out_addr;
    logic              out_last;

    modport master (output out_valid, out_data, out_addr, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_addr, out_last, output out_ready);
endinterface

// File: rtl/mem44_drain.sv
// Result collector for the NxN systolic array: captures N skewed lane streams
// into an NxN byte buffer, then drains it row-major with {row,col} addresses.
module mem44_drain #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      lane_valid,
    input  logic [N*DW-1:0]   lane_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    mem44_drain_if.master     out_if
);
    localparam int AW = $clog2(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    localparam logic [AW:0]     FULL = (AW+1)'(N);
    localparam logic [AW:0]     NEAR = (AW+1)'(N-1);
    localparam logic [2*AW-1:0] LAST = (2*AW)'(N*N-1);

    logic [1:0]      state;
    logic [AW:0]     wr_ptr [N];
    logic [2*AW-1:0] rd_ptr;
    logic [DW-1:0]   mem [N*N];
    logic [N-1:0]    lane_full_next;

    // A lane counts as full if it already is, or its Nth byte lands this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lane_full_next = '0;
        for (int i = 0; i < N; i++)
            lane_full_next[i] = (wr_ptr[i] == FULL) || (lane_valid[i] && wr_ptr[i] == NEAR);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < N; i++)
                wr_ptr[i] <= '0;
            // NOTE: the buffer is deliberately cleared on reset, so it stays in flops rather than a RAM macro.
            for (int k = 0; k < N*N; k++)
                mem[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CAPTURE;
                        overflow <= 1'b0;
                        for (int i = 0; i < N; i++)
                            wr_ptr[i] <= '0;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < N; i++) begin
                        if (lane_valid[i]) begin
                            if (wr_ptr[i] == FULL) begin
                                overflow <= 1'b1;
                            end else begin
                                mem[{AW'(i), wr_ptr[i][AW-1:0]}] <= lane_data[i*DW +: DW];
                                wr_ptr[i] <= wr_ptr[i] + 1'b1;
                            end
                        end
                    end
                    if (&lane_full_next) begin
                        state  <= S_DRAIN;
                        rd_ptr <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_if.out_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == LAST) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The buffer is frozen during DRAIN, so a read indexed by the registered
    // rd_ptr is stable for as long as the consumer stalls.
    assign busy             = (state != S_IDLE);
    assign out_if.out_valid = (state == S_DRAIN);
    assign out_if.out_addr  = rd_ptr;
    assign out_if.out_data  = mem[rd_ptr];
    assign out_if.out_last  = (state == S_DRAIN) && (rd_ptr == LAST);
endmodule
